// File: rtl/encoder_pkg.sv
// Shared types and constants for the 4-to-2 priority encoder.
// Optional multi-hot detection is controlled by ENC_MULTIHOT_ERR_EN.
package encoder_pkg;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 2;

    typedef logic [IN_W-1:0]  enc_in_t;
    typedef logic [OUT_W-1:0] enc_idx_t;

    localparam enc_idx_t IDX_NONE = 2'b00;

    // True when more than one request bit is set (clearing the lowest set bit leaves something).
    function automatic logic is_multi_hot(input enc_in_t a);
        return (a & (a - enc_in_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational MSB-priority encode of the request vector into next-state values.
// The multi_hot_next output exists only when ENC_MULTIHOT_ERR_EN is defined.
module encoder_4to2_core
    import encoder_pkg::*;
(
    input  logic [IN_W-1:0]  A,
    output logic [OUT_W-1:0] y_next,
    output logic             valid_next
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic             multi_hot_next
`endif
);

    always_comb begin
        y_next     = IDX_NONE;
        valid_next = 1'b0;
        casez (A)
            4'b1???: begin y_next = 2'b11; valid_next = 1'b1; end
            4'b01??: begin y_next = 2'b10; valid_next = 1'b1; end
            4'b001?: begin y_next = 2'b01; valid_next = 1'b1; end
            4'b0001: begin y_next = 2'b00; valid_next = 1'b1; end
            default: begin y_next = IDX_NONE; valid_next = 1'b0; end
        endcase
    end

`ifdef ENC_MULTIHOT_ERR_EN
    always_comb begin
        multi_hot_next = is_multi_hot(A);
    end
`endif

endmodule

// File: rtl/encoder_4to2_behav.sv
// Registered 4-to-2 priority encoder with valid flag; async active-high reset.
// Define ENC_MULTIHOT_ERR_EN to add the registered multi_hot output.
module encoder_4to2_behav
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  A,
    output logic [OUT_W-1:0] Y,
    output logic             valid
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic             multi_hot
`endif
);

    enc_idx_t y_next;
    logic     valid_next;

`ifdef ENC_MULTIHOT_ERR_EN
    logic     multi_hot_next;
`endif

    encoder_4to2_core u_core (
        .A              (A),
        .y_next         (y_next),
        .valid_next     (valid_next)
`ifdef ENC_MULTIHOT_ERR_EN
        ,
        .multi_hot_next (multi_hot_next)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y     <= IDX_NONE;
            valid <= 1'b0;
        end else begin
            Y     <= y_next;
            valid <= valid_next;
        end
    end

`ifdef ENC_MULTIHOT_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_hot <= 1'b0;
        end else begin
            multi_hot <= multi_hot_next;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_4to2_behav.sv
// Self-checking bench for encoder_4to2_behav: vector table, reset corners, exhaustive and random.
// Checks multi_hot as well when ENC_MULTIHOT_ERR_EN is defined.
module tb_encoder_4to2_behav;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A;
    logic [1:0] Y;
    logic       valid;
`ifdef ENC_MULTIHOT_ERR_EN
    logic       multi_hot;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    encoder_4to2_behav dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .Y         (Y),
        .valid     (valid)
`ifdef ENC_MULTIHOT_ERR_EN
        ,
        .multi_hot (multi_hot)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [1:0] y;
        logic       v;
        logic       mh;
    } vec_t;

    // Reference: index of the highest set bit, found by scanning upward.
    function automatic logic [1:0] ref_y(input logic [3:0] a);
        logic [1:0] idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (a[i]) idx = 2'(i);
        return idx;
    endfunction

    task automatic check(input string name, input logic [1:0] ey, input logic ev, input logic emh);
        tests_run++;
        if (Y !== ey || valid !== ev) begin
            tests_failed++;
            $display("FAIL %s: got Y=%b valid=%b, expected Y=%b valid=%b", name, Y, valid, ey, ev);
        end
`ifdef ENC_MULTIHOT_ERR_EN
        tests_run++;
        if (multi_hot !== emh) begin
            tests_failed++;
            $display("FAIL %s multi_hot: got %b, expected %b", name, multi_hot, emh);
        end
`else
        if (emh === 1'bx) $display("unexpected x expectation in %s", name);
`endif
    endtask

    // Drive A away from the active edge, then land 1 unit after the capturing edge.
    task automatic step(input logic [3:0] a);
        @(negedge clk);
        A = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name, input logic [3:0] a);
        check(name, ref_y(a), a != 4'd0, $countones(a) > 1);
    endtask

    vec_t tbl[$];

    initial begin
        // One-hot sweep, zero, multi-hot priority, then back-to-back pattern.
        tbl.push_back('{4'b0001, 2'b00, 1'b1, 1'b0});
        tbl.push_back('{4'b0010, 2'b01, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 2'b10, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 2'b11, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 2'b00, 1'b0, 1'b0});
        tbl.push_back('{4'b1111, 2'b11, 1'b1, 1'b1});
        tbl.push_back('{4'b0011, 2'b01, 1'b1, 1'b1});
        tbl.push_back('{4'b0110, 2'b10, 1'b1, 1'b1});
        tbl.push_back('{4'b1001, 2'b11, 1'b1, 1'b1});
        tbl.push_back('{4'b0001, 2'b00, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 2'b11, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 2'b00, 1'b0, 1'b0});
        tbl.push_back('{4'b0100, 2'b10, 1'b1, 1'b0});

        // Reset held across edges with a request present: outputs stay cleared.
        rst = 1'b1;
        A   = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 2'b00, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", 2'b11, 1'b1, 1'b0);

        // Mid-cycle async reset clears immediately, without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_midcycle", 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_blocks_capture", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table: check right after the edge and again just before the next drive.
        foreach (tbl[i]) begin
            step(tbl[i].a);
            check($sformatf("table[%0d]_a=%b", i, tbl[i].a), tbl[i].y, tbl[i].v, tbl[i].mh);
            #3;
            check($sformatf("table[%0d]_hold", i), tbl[i].y, tbl[i].v, tbl[i].mh);
        end

        // One-cycle latency: output still shows the previous value until the edge.
        step(4'b0010);
        @(negedge clk);
        A = 4'b1100;
        #3;
        check("latency_before_edge", 2'b01, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("latency_after_edge", 2'b11, 1'b1, 1'b1);

        for (int v = 0; v < 16; v++) begin
            step(4'(v));
            check_model($sformatf("exhaustive_a=%b", 4'(v)), 4'(v));
        end

        for (int n = 0; n < 200; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            step(r);
            check_model($sformatf("random[%0d]_a=%b", n, r), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
